inst_queue: RTL
===============

Name: inst_queue

Overview:
- Receiving end of the fetch output interface: captures (pc, inst, valid) from fetch into a FIFO and presents entries to decode with a valid/ready handshake.
- Drives stall back to fetch early enough to absorb instructions already in the fetch pipeline.
- Discards wrong-path entries after a branch redirect (flush).

Parameters:
- DEPTH, 8, number of entries; must be a power of 2 and >= 4.
- SKID, 2, free slots reserved for in-flight fetch entries when stall_o asserts.
- FLUSH_DROP, 2, incoming valid entries discarded after a flush (wrong-path entries in the fetch pipeline).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_ni  input  1  asynchronous reset, active-low.
- pc_i  input  32  fetched instruction address, from fetch.
- inst_i  input  32  fetched instruction word, from fetch.
- inst_valid_i  input  1  pc_i/inst_i valid this cycle.
- stall_o  output  1  to fetch; hold PC.
- flush_i  input  1  branch redirect; clears the queue.
- deq_valid_o  output  1  head entry available.
- deq_ready_i  input  1  decode accepts the head entry.
- deq_pc_o  output  32  head entry pc.
- deq_inst_o  output  32  head entry instruction.
- count_o  output  $clog2(DEPTH)+1  current occupancy.
- overflow_o  output  1  sticky; an entry was lost because the queue was full.

Behaviour:
- Reset (reset_ni=0, asynchronous):
  - rd_ptr=wr_ptr=0, count_o=0, drop counter=0, overflow_o=0.
  - deq_valid_o=0, stall_o=0, deq_pc_o=0, deq_inst_o=0.
  - Storage contents are don't-care.
  - Deasserting reset mid-operation leaves the queue empty; nothing survives.
- Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0. Occupancy is a separate counter with 0..DEPTH range.
- Enqueue fires when inst_valid_i=1, flush_i=0, drop counter=0, and (count<DEPTH or a dequeue fires the same cycle).
  - Entry is written at wr_ptr; wr_ptr increments.
- Dequeue fires when deq_valid_o & deq_ready_i.
  - rd_ptr increments.
  - deq_valid_o = (count!=0).
  - deq_pc_o/deq_inst_o are driven combinationally from storage at rd_ptr. Read-to-output latency is 0 cycles; enqueue-to-visible latency is 1 cycle.
- Simultaneous enqueue and dequeue leaves count unchanged. This is legal when full (DEPTH) and when count=1.
- Full with no dequeue and inst_valid_i=1 (not dropped):
  - Entry is discarded and overflow_o sets to 1.
  - overflow_o stays set until reset.
- stall_o = (count >= DEPTH-SKID), registered. It is the registered value of the next-state count, so it reflects the post-edge occupancy.
- Flush (flush_i=1) has priority over everything else in that cycle:
  - Pointers and count go to 0.
  - Any enqueue or dequeue in that cycle is suppressed. deq_valid_o is still driven combinationally; decode must ignore it while flush_i=1.
  - Drop counter is loaded with FLUSH_DROP. The entry arriving in the flush cycle is discarded and does not decrement the counter.
  - stall_o=0 the next cycle.
- Drop window: while drop counter>0, each inst_valid_i=1 cycle discards the entry and decrements the counter. Cycles with inst_valid_i=0 do not decrement.
- A second flush during the drop window reloads the counter to FLUSH_DROP.
- overflow_o is not set by dropped entries.

Optional Feature:
- Macro: INST_QUEUE_BYPASS_EN.
- With the macro defined:
  - When count=0, drop counter=0, flush_i=0 and inst_valid_i=1, the outputs are deq_valid_o=1, deq_pc_o=pc_i, deq_inst_o=inst_i, combinationally in the same cycle.
  - If deq_ready_i=1, the entry is consumed and not written; count stays 0.
  - If deq_ready_i=0, the entry is enqueued normally.
- Without the macro: no combinational path from fetch inputs to deq outputs; minimum 1-cycle latency.

Test Plan:
- Basic FIFO order: reset, then enqueue pc 0x0,0x4,0x8 with deq_ready_i=0, then deq_ready_i=1 -> deq_pc_o yields 0x0,0x4,0x8 on consecutive cycles; count_o goes 3,2,1,0; deq_valid_o=0 after.
- Stall threshold: DEPTH=8, SKID=2, continuous enqueue with deq_ready_i=0 -> stall_o=1 the cycle after count reaches 6; 2 further entries accepted (count=8); a 9th entry sets overflow_o=1 and count stays 8.
- Full with simultaneous enqueue and dequeue: count=8, inst_valid_i=1, deq_ready_i=1 -> count stays 8, overflow_o stays 0, wr_ptr/rd_ptr both wrap 7->0 correctly over 16 cycles.
- Flush drop window: count=5, flush_i=1 with inst_valid_i=1 -> next cycle count=0 and stall_o=0; next 2 valid entries (pc 0x40,0x44) dropped; 3rd (pc 0x100) enqueued and appears at deq_pc_o.
- Async reset mid-stream: reset_ni pulsed low between edges with count=4 and overflow_o=1 -> outputs clear immediately without a clock edge, and stay cleared afterwards.
- Bypass (INST_QUEUE_BYPASS_EN defined): empty queue, inst_valid_i=1, pc_i=0x20, deq_ready_i=1 -> deq_valid_o=1 and deq_pc_o=0x20 in the same cycle, count stays 0. Macro undefined -> deq_valid_o=0 that cycle, 1 the next.

Source files
------------

// File: rtl/inst_queue.sv
// inst_queue: fetch-to-decode instruction FIFO with early stall, flush drop window and overflow flag.
// Optional INST_QUEUE_BYPASS_EN adds a same-cycle path from fetch to decode when the queue is empty.
module inst_queue #(
   parameter int DEPTH      = 8,
   parameter int SKID       = 2,
   parameter int FLUSH_DROP = 2
) (
   input  logic                       clk_i,
   input  logic                       reset_ni,
   input  logic [31:0]                pc_i,
   input  logic [31:0]                inst_i,
   input  logic                       inst_valid_i,
   output logic                       stall_o,
   input  logic                       flush_i,
   output logic                       deq_valid_o,
   input  logic                       deq_ready_i,
   output logic [31:0]                deq_pc_o,
   output logic [31:0]                deq_inst_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       overflow_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = $clog2(FLUSH_DROP + 1);
   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   inst_mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count, count_nxt;
   logic [DW-1:0] drop_cnt;
   logic          empty, full, accept, byp, deq_fire, enq_fire, ovf_set;
   always_comb begin
      empty     = (count == '0);
      full      = (count == CW'(DEPTH));
      accept    = inst_valid_i & ~flush_i & (drop_cnt == '0);
`ifdef INST_QUEUE_BYPASS_EN
      byp       = accept & empty;
`else
      byp       = 1'b0;
`endif
      deq_valid_o = ~empty | byp;
      deq_pc_o    = ~empty ? pc_mem[rd_ptr]   : byp ? pc_i   : '0;
      deq_inst_o  = ~empty ? inst_mem[rd_ptr] : byp ? inst_i : '0;
      deq_fire  = ~empty & deq_ready_i & ~flush_i;
      // a bypassed entry taken by decode never occupies a slot
      enq_fire  = accept & (~full | deq_fire) & ~(byp & deq_ready_i);
      ovf_set   = accept & full & ~deq_fire;
      count_nxt = flush_i ? '0 : count + CW'(enq_fire) - CW'(deq_fire);
   end
   assign count_o = count;
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         drop_cnt   <= '0;
         overflow_o <= 1'b0;
         stall_o    <= 1'b0;
      end else begin
         count   <= count_nxt;
         stall_o <= (count_nxt >= CW'(DEPTH - SKID));
         if (flush_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            drop_cnt <= DW'(FLUSH_DROP);
         end else begin
            if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
            if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
            if (inst_valid_i && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
            if (ovf_set) overflow_o <= 1'b1;
         end
      end
   end
   always_ff @(posedge clk_i) begin
      if (enq_fire) begin
         pc_mem[wr_ptr]   <= pc_i;
         inst_mem[wr_ptr] <= inst_i;
      end
   end
endmodule
